// File: rtl/dbnc_pkg.sv
// Shared types and helpers for the push-button / switch debouncer.
package dbnc_pkg;

  // Per-channel debounce state: two settled states, each with a pending-change state.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } dbnc_state_t;

  // Bits needed to count 0..n-1. $clog2 gives 0 for n=1, so clamp to one bit
  // to keep every counter a legal vector.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dbnc_chan.sv
// One debounce channel: a four-state FSM that accepts a level change only
// after the synchronised input has held its new value for STABLE_TICKS
// sample ticks. Outputs are registered: level, plus one-cycle rise/fall strobes.
module dbnc_chan
  import dbnc_pkg::*;
#(
  parameter int   STABLE_TICKS = 10,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,    // asynchronous, active-low
  input  logic tick,   // shared sample tick from the prescaler
  input  logic s2,     // synchronised input bit
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam dbnc_state_t   ST_RESET = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  dbnc_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Next-state logic: a contrary input in WAIT always wins over tick, so a
  // glitch is discarded even on the cycle that would otherwise accept it.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s2) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_d = STABLE_LO;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_d = STABLE_HI;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State, counter and output registers; reset lands in the settled state
  // matching RESET_LEVEL so neither reset nor its release makes a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Input conditioner for N push-buttons / switches: 2-FF synchroniser,
// shared sample-tick prescaler and one debounce channel per input.
module btn_debounce
  import dbnc_pkg::*;
#(
  parameter int   N            = 8,
  parameter int   TICK_DIV     = 100000,
  parameter int   STABLE_TICKS = 10,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,     // asynchronous, active-low
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int            PW        = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  logic [N-1:0]  s1_q, s2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // Two-stage synchroniser; both stages start at the reset level so the
  // channels see no change when reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= {N{RESET_LEVEL}};
      s2_q <= {N{RESET_LEVEL}};
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // Prescaler wraps 0..TICK_DIV-1; tick marks the last count. With
  // TICK_DIV=1 the counter sits at 0 and tick is high every cycle.
  assign tick = (presc_q == PRESC_TOP);

  // Next prescaler count.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    dbnc_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .s2    (s2_q[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule
